// File: rtl/enum_alu_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : enum_alu_pipe_if
//  Description : Command/result handshake bundle for enum_alu_pipe.
//                master = command source + result consumer, slave = the ALU.
//  Revision    : 1.0  initial release
// ============================================================================
interface enum_alu_pipe_if #(
    parameter int NBITS = 8,
    parameter int OPW   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   opc;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] xout;
    logic             ovf;

    modport master (
        output in_valid, opc, a, b, out_ready,
        input  in_ready, out_valid, xout, ovf
    );

    modport slave (
        input  in_valid, opc, a, b, out_ready,
        output in_ready, out_valid, xout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/enum_alu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : enum_alu_pipe
//  Description : Two-stage opcode-dispatch ALU (INC/ADD/SUB/ACC/CLR, anything
//                else multiplies) with valid/ready on both sides, a persistent
//                accumulator and optional result saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module enum_alu_pipe #(
    parameter int             NBITS    = 8,
    parameter int             OPW      = 8,
    parameter logic [OPW-1:0] OP_INC   = OPW'(17),
    parameter logic [OPW-1:0] OP_ADD   = OPW'(18),
    parameter logic [OPW-1:0] OP_SUB   = OPW'(19),
    parameter logic [OPW-1:0] OP_ACC   = OPW'(20),
    parameter logic [OPW-1:0] OP_CLR   = OPW'(21),
    parameter bit             SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    enum_alu_pipe_if.slave  bus
);

    typedef enum logic [2:0] {
        K_INC = 3'd0,
        K_ADD = 3'd1,
        K_SUB = 3'd2,
        K_ACC = 3'd3,
        K_CLR = 3'd4,
        K_MUL = 3'd5
    } op_kind_t;

    // Stage 1: captured command
    logic             r_s1_valid;
    logic [OPW-1:0]   r_s1_opc;
    logic [NBITS-1:0] r_s1_a;
    logic [NBITS-1:0] r_s1_b;

    // Stage 2: registered result
    logic             r_out_valid;
    logic [NBITS-1:0] r_xout;
    logic             r_ovf;

    logic [NBITS-1:0] r_acc;

    logic             w_s2_free;
    logic             w_move;
    logic             w_in_ready;
    logic             w_in_fire;
    op_kind_t         w_kind;

    logic [NBITS:0]     w_add_a1;
    logic [NBITS:0]     w_add_ab;
    logic [NBITS:0]     w_sub_ab;
    logic [NBITS:0]     w_add_acc;
    logic [2*NBITS-1:0] w_mul;

    logic [NBITS-1:0] w_raw;
    logic             w_raw_ovf;
    logic             w_sat_low;
    logic [NBITS-1:0] w_res;

    // Output register can take a new result when empty or being drained this cycle
    assign w_s2_free  = !r_out_valid || bus.out_ready;
    assign w_move     = r_s1_valid && w_s2_free;
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.xout      = r_xout;
    assign bus.ovf       = r_ovf;

    // Arithmetic is done one bit wider (double width for multiply) so the top bit is carry/borrow
    assign w_add_a1  = {1'b0, r_s1_a} + {{NBITS{1'b0}}, 1'b1};
    assign w_add_ab  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_sub_ab  = {1'b0, r_s1_a} - {1'b0, r_s1_b};
    assign w_add_acc = {1'b0, r_acc}  + {1'b0, r_s1_a};
    assign w_mul     = {{NBITS{1'b0}}, r_s1_a} * {{NBITS{1'b0}}, r_s1_b};

    // Decode the parametrised opcode into an operation kind; unmatched codes multiply
    always_comb begin
        w_kind = K_MUL;
        case (r_s1_opc)
            OP_INC:  w_kind = K_INC;
            OP_ADD:  w_kind = K_ADD;
            OP_SUB:  w_kind = K_SUB;
            OP_ACC:  w_kind = K_ACC;
            OP_CLR:  w_kind = K_CLR;
            default: w_kind = K_MUL;
        endcase
    end

    // Select the wrapped result and its overflow/borrow flag for the decoded operation
    always_comb begin
        w_raw     = '0;
        w_raw_ovf = 1'b0;
        w_sat_low = 1'b0;
        case (w_kind)
            K_INC: begin
                w_raw     = w_add_a1[NBITS-1:0];
                w_raw_ovf = w_add_a1[NBITS];
            end
            K_ADD: begin
                w_raw     = w_add_ab[NBITS-1:0];
                w_raw_ovf = w_add_ab[NBITS];
            end
            K_SUB: begin
                w_raw     = w_sub_ab[NBITS-1:0];
                w_raw_ovf = w_sub_ab[NBITS];
                w_sat_low = 1'b1;
            end
            K_ACC: begin
                w_raw     = w_add_acc[NBITS-1:0];
                w_raw_ovf = w_add_acc[NBITS];
            end
            K_CLR: begin
                w_raw     = r_acc;
                w_raw_ovf = 1'b0;
            end
            default: begin
                w_raw     = w_mul[NBITS-1:0];
                w_raw_ovf = |w_mul[2*NBITS-1:NBITS];
            end
        endcase
    end

    // Optional clamp: borrow clamps to zero, every other overflow to all-ones
    always_comb begin
        w_res = w_raw;
        if (SATURATE && w_raw_ovf) begin
            w_res = w_sat_low ? '0 : '1;
        end
    end

    // Stage 1 register: load on accept, empty when its command moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_opc   <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_opc   <= bus.opc;
                r_s1_a     <= bus.a;
                r_s1_b     <= bus.b;
            end else if (w_move) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register: capture result on move, hold while stalled, drop valid when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_xout      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_move) begin
                r_out_valid <= 1'b1;
                r_xout      <= w_res;
                r_ovf       <= w_raw_ovf;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Accumulator changes only when its ACC/CLR command moves into stage 2, keeping result order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_move) begin
            if (w_kind == K_ACC) begin
                r_acc <= w_res;
            end else if (w_kind == K_CLR) begin
                r_acc <= '0;
            end
        end
    end

endmodule
`default_nettype wire
